// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler that owns a shared 4-bit counter for one run at a time.
// Each run: clear the counter, count up to the latched terminal value, then pulse done.
module counter_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [3:0] cnt_out,
  output logic       cnt_en,
  output logic       cnt_rst,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t     state;
  logic [3:0] len_q;
  logic       last1;     // requester 1 finished the most recent run, so 0 wins a tie
  logic       owner_req;
  logic       pick1;

  assign owner_req = (gnt0 & req0) | (gnt1 & req1);
  assign pick1     = req1 & (~req0 | ~last1);

  // Counting stops on the terminal value and the moment the owner abandons the run.
  assign cnt_en = (state == RUN) & owner_req & (cnt_out != len_q);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      cnt_rst <= 1'b0;
      len_q   <= 4'd0;
      last1   <= 1'b1;
    end else begin
      done0   <= 1'b0;
      done1   <= 1'b0;
      cnt_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state   <= CLR;
            gnt0    <= ~pick1;
            gnt1    <= pick1;
            len_q   <= pick1 ? len1 : len0;
            cnt_rst <= 1'b1;
          end
        end
        CLR: begin
          if (!owner_req) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!owner_req) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
          end else if (cnt_out == len_q) begin
            state <= DONE;
            done0 <= gnt0;
            done1 <= gnt1;
            last1 <= gnt1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: models a run as "cycles elapsed since grant" and checks every cycle,
// plus directed scenarios with hand-computed latencies and counter values.
module tb_counter_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic [3:0] cnt_out = 4'd0;
  logic       cnt_en, cnt_rst, gnt0, gnt1, done0, done1, busy;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Reference: an active run is owned by m_who; m_age = cycles since the grant edge
  // (1 = clear cycle, 2..len+2 = counting, len+3 = done cycle).
  bit m_act = 1'b0, m_who = 1'b0, m_last = 1'b1;
  int m_len = 0, m_age = 0;

  counter_sched dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .cnt_out(cnt_out), .cnt_en(cnt_en), .cnt_rst(cnt_rst), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .busy(busy)
  );

  always #5 clk = ~clk;

  // The shared counter the scheduler drives.
  always @(posedge clk) begin
    if (cnt_rst) cnt_out <= 4'd0;
    else if (cnt_en) cnt_out <= cnt_out + 4'd1;
  end

  function automatic void model_step();
    if (!rst) begin
      m_act  = 1'b0;
      m_last = 1'b1;
    end else if (!m_act) begin
      if (req0 || req1) begin
        m_who = (req0 && req1) ? !m_last : req1;
        m_len = m_who ? int'(len1) : int'(len0);
        m_act = 1'b1;
        m_age = 1;
      end
    end else if (m_age == m_len + 3) begin
      m_act = 1'b0;
    end else if (!(m_who ? req1 : req0)) begin
      m_act = 1'b0;
    end else begin
      m_age++;
      if (m_age == m_len + 3) m_last = m_who;
    end
  endfunction

  task automatic cmp(input string nm, input logic act, input logic exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic oreq, dn;
    if (chk_on) begin
      oreq = m_who ? req1 : req0;
      dn   = m_act && (m_age == m_len + 3);
      vectors++;
      cmp("gnt0", gnt0, m_act && !m_who);
      cmp("gnt1", gnt1, m_act && m_who);
      cmp("busy", busy, m_act);
      cmp("cnt_rst", cnt_rst, m_act && m_age == 1);
      cmp("cnt_en", cnt_en, m_act && oreq && m_age >= 2 && m_age <= m_len + 1);
      cmp("done0", done0, dn && !m_who);
      cmp("done1", done1, dn && m_who);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Cycles from the next (grant) edge until the requested done pulse; -1 on timeout.
  task automatic run_done(input bit which, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      @(negedge clk);
      if (which ? done1 : done0) return;
    end
    n = -1;
  endtask

  initial begin
    int n;
    int order [4];
    bit found;

    // Reset state
    tick();
    chk_on = 1'b1;
    @(negedge clk);
    lit("rst_gnt", {gnt0, gnt1}, 0);
    lit("rst_busy", busy, 0);
    lit("rst_cnt_ctl", {cnt_en, cnt_rst}, 0);
    lit("rst_done", {done0, done1}, 0);
    tick();
    rst = 1'b1;

    // Single run, len 3
    len0 = 4'd3; req0 = 1'b1;
    run_done(0, n);
    lit("single_latency", n, 6);
    lit("single_cnt", cnt_out, 3);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    lit("single_gnt_after", gnt0, 0);
    lit("single_busy_after", busy, 0);

    // Contention from a fresh pointer: grants alternate starting with 0
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    len0 = 4'd2; len1 = 4'd5; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      order[k] = 9;
      for (int i = 0; i < 40; i++) begin
        tick();
        @(negedge clk);
        if (done0 || done1) begin
          order[k] = done1 ? 1 : 0;
          break;
        end
      end
      lit($sformatf("rr_order%0d", k), order[k], k % 2);
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;

    // Zero length: counter was left at 5, must clear and stay 0
    req1 = 1'b1; len1 = 4'd0;
    run_done(1, n);
    lit("zero_latency", n, 3);
    lit("zero_cnt", cnt_out, 0);
    tick();
    req1 = 1'b0;

    // Maximum length: reaches 15 without wrapping and holds
    req0 = 1'b1; len0 = 4'd15;
    run_done(0, n);
    lit("max_latency", n, 18);
    lit("max_cnt", cnt_out, 15);
    tick();
    req0 = 1'b0;
    tick();
    @(negedge clk);
    lit("max_hold", cnt_out, 15);

    // Abort at cnt_out == 2 in a len 7 run; pointer must still favour req0
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    req0 = 1'b1; len0 = 4'd7;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (busy && cnt_out == 4'd1) begin
        found = 1'b1;
        break;
      end
    end
    lit("abort_reach", found, 1);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    lit("abort_cnt_en", cnt_en, 0);
    tick();
    @(negedge clk);
    lit("abort_busy", busy, 0);
    lit("abort_no_done", done0, 0);
    lit("abort_cnt_held", cnt_out, 2);
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    @(negedge clk);
    lit("abort_ptr_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reset in the middle of a run
    req1 = 1'b1; len1 = 4'd9;
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    lit("midrst_gnt", {gnt0, gnt1}, 0);
    lit("midrst_busy", busy, 0);
    lit("midrst_ctl", {cnt_en, cnt_rst}, 0);
    lit("midrst_done", {done0, done1}, 0);
    tick();
    rst = 1'b1; req0 = 1'b1;
    tick();
    @(negedge clk);
    lit("midrst_regrant", {gnt0, gnt1}, 2);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Randomized traffic, lengths changing every cycle, occasional resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst  = ($urandom_range(0, 199) != 0);
      len0 = 4'($urandom);
      len1 = 4'($urandom);
      req0 = req0 ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 3) == 0);
      req1 = req1 ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 3) == 0);
    end
    tick();
    @(negedge clk);
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
